clock_monitor: RTL

Synthesizable checker for a clock-like signal of unknown phase, such as a generated or divided clock, a forwarded clock or a strobe. It samples `testClk` on the system clock `clk` and measures each period and high time in `clk` cycles. It flags periods outside a window and flags a stuck input. It sits on the consumer side of any clock source in the design and feeds status registers and self-checking benches.

---
 rtl/clock_monitor.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/clock_monitor.sv
// Measures period and high time of a clock-like input sampled on clk, and flags
// out-of-window periods and a stuck (edgeless) input.
module clock_monitor #(
    parameter int COUNT_WIDTH = 16,
    parameter int MIN_PERIOD  = 4,
    parameter int MAX_PERIOD  = 64,
    parameter int TIMEOUT     = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   testClk,
    output logic [COUNT_WIDTH-1:0] period,
    output logic [COUNT_WIDTH-1:0] highTime,
    output logic                   measValid,
    output logic                   outOfRange,
    output logic                   stuck,
    output logic [7:0]             edgeCount
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_e;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [COUNT_WIDTH-1:0] TO_LAST  = COUNT_WIDTH'(TIMEOUT - 1);
    localparam logic [COUNT_WIDTH:0]   MIN_P    = (COUNT_WIDTH + 1)'(MIN_PERIOD);
    localparam logic [COUNT_WIDTH:0]   MAX_P    = (COUNT_WIDTH + 1)'(MAX_PERIOD);

    logic                   s1_q, s2_q, s3_q;
    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [COUNT_WIDTH-1:0] period_q, period_d;
    logic [COUNT_WIDTH-1:0] high_q, high_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   oor_q, oor_d;
    logic                   stuck_q, stuck_d;
    logic [7:0]             edge_cnt_q, edge_cnt_d;

    logic                   rise;
    logic [COUNT_WIDTH:0]   per_full;
    logic [COUNT_WIDTH-1:0] per_sat;

    assign rise     = s2_q & ~s3_q;
    // One extra bit so the window compare sees the true cnt+1 even at saturation.
    assign per_full = {1'b0, cnt_q} + (COUNT_WIDTH + 1)'(1);
    assign per_sat  = per_full[COUNT_WIDTH] ? CNT_MAX : per_full[COUNT_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hcnt_d       = hcnt_q;
        period_d     = period_q;
        high_d       = high_q;
        meas_valid_d = 1'b0;
        oor_d        = oor_q;
        stuck_d      = stuck_q;
        edge_cnt_d   = edge_cnt_q;

        if (!enable) begin
            // Dropping enable discards any measurement in flight.
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
            oor_d   = 1'b0;
            stuck_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    oor_d   = 1'b0;
                    stuck_d = 1'b0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = '0;
                        hcnt_d  = CNT_ONE;
                        state_d = MEASURE;
                    end else if (cnt_q == TO_LAST) begin
                        stuck_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                MEASURE: begin
                    // A rise coinciding with the timeout cycle still counts as a rise.
                    if (rise) begin
                        period_d     = per_sat;
                        high_d       = hcnt_q;
                        meas_valid_d = 1'b1;
                        edge_cnt_d   = edge_cnt_q + 8'd1;
                        oor_d        = (per_full < MIN_P) || (per_full > MAX_P);
                        stuck_d      = 1'b0;
                        cnt_d        = '0;
                        hcnt_d       = CNT_ONE;
                    end else if (cnt_q == TO_LAST) begin
                        stuck_d = 1'b1;
                        cnt_d   = '0;
                        hcnt_d  = '0;
                        state_d = ARM;
                    end else begin
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                        if (s2_q && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            period_q     <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            oor_q        <= 1'b0;
            stuck_q      <= 1'b0;
            edge_cnt_q   <= '0;
        end else begin
            s1_q         <= testClk;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            meas_valid_q <= meas_valid_d;
            oor_q        <= oor_d;
            stuck_q      <= stuck_d;
            edge_cnt_q   <= edge_cnt_d;
        end
    end

    assign period     = period_q;
    assign highTime   = high_q;
    assign measValid  = meas_valid_q;
    assign outOfRange = oor_q;
    assign stuck      = stuck_q;
    assign edgeCount  = edge_cnt_q;

endmodule
